mips_dmem_bridge: RTL

- Data-side neighbour of the single-cycle MIPS core: consumes the core's memwrite, aluout (address) and writedata, and returns readdata.
- Decodes each access to either a word-addressed data RAM or a small MMIO page. The page holds a byte TX FIFO with a valid/ready drain port, a free-running cycle timer and an LED register.
- Reads are combinational so the core's single-cycle lw still completes in one cycle; all writes take effect on the rising clk edge.

---
 rtl/mips_io_pkg.sv | 17 +
 rtl/io_fifo.sv | 55 +++++
 rtl/mips_dmem_bridge.sv | 116 +++++++++++
 3 files changed

// File: rtl/mips_io_pkg.sv
// Shared constants for the MIPS data-side bridge: MMIO page base,
// register offsets and STATUS bit positions.
package mips_io_pkg;

    localparam logic [15:0] IO_BASE    = 16'hFFFF;

    localparam logic [15:0] OFS_TXDATA = 16'h0000;
    localparam logic [15:0] OFS_STATUS = 16'h0004;
    localparam logic [15:0] OFS_TIMER  = 16'h0008;
    localparam logic [15:0] OFS_LEDS   = 16'h000C;

    localparam int unsigned ST_EMPTY     = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_OVF       = 2;
    localparam int unsigned ST_COUNT_LSB = 8;

endpackage

// File: rtl/io_fifo.sv
// Small synchronous FIFO feeding the MMIO TX drain port.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mips_dmem_bridge.sv
// Data-side bridge for the single-cycle MIPS core: word RAM plus an MMIO
// page with TX FIFO, free-running timer and LED register.
module mips_dmem_bridge
    import mips_io_pkg::*;
#(
    parameter int          RAM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] IO_BASE    = mips_io_pkg::IO_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  leds
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ram [RAM_WORDS];
    logic [AW-1:0] idx;
    logic          io_sel;
    logic [15:0]   ofs;
    logic          unused_ok;

    logic sel_tx, sel_st, sel_tm, sel_led;
    logic push, pop, ram_we, st_we, tm_we, led_we;

    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_drop;
    logic          ovf;
    logic [31:0]   timer;
    logic [31:0]   status;

    // Byte lanes are ignored; offsets compare on word granularity.
    assign io_sel    = (addr[31:16] == IO_BASE);
    assign ofs       = {addr[15:2], 2'b00};
    assign idx       = addr[AW+1:2];
    assign unused_ok = ^addr[1:0];

    assign sel_tx  = io_sel && (ofs == OFS_TXDATA);
    assign sel_st  = io_sel && (ofs == OFS_STATUS);
    assign sel_tm  = io_sel && (ofs == OFS_TIMER);
    assign sel_led = io_sel && (ofs == OFS_LEDS);

    assign ram_we = memwrite & ~io_sel;
    assign push   = memwrite & sel_tx;
    assign st_we  = memwrite & sel_st;
    assign tm_we  = memwrite & sel_tm;
    assign led_we = memwrite & sel_led;

    assign tx_valid = ~fifo_empty;
    assign pop      = tx_valid & tx_ready;

    io_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (writedata[7:0]),
        .dout  (tx_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    always_ff @(posedge clk) begin
        if (ram_we) ram[idx] <= writedata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
            leds  <= '0;
            ovf   <= 1'b0;
        end else begin
            timer <= tm_we ? writedata : timer + 32'd1;
            if (led_we) leds <= writedata[7:0];
            if (fifo_drop)
                ovf <= 1'b1;
            else if (st_we && writedata[ST_OVF])
                ovf <= 1'b0;
        end
    end

    always_comb begin
        status                       = '0;
        status[ST_COUNT_LSB +: 8]    = 8'(fifo_count);
        status[ST_OVF]               = ovf;
        status[ST_FULL]              = fifo_full;
        status[ST_EMPTY]             = fifo_empty;
    end

    always_comb begin
        readdata = '0;
        unique case (1'b1)
            !io_sel: readdata = ram[idx];
            sel_st:  readdata = status;
            sel_tm:  readdata = timer;
            sel_led: readdata = {24'h0, leds};
            default: readdata = '0;
        endcase
    end

endmodule
